spi_target: RTL and testbench

//  SPI target (slave) engine: the far end of the link driven by our SPI master.

---
 rtl/spi_target_pkg.sv | 13 +
 rtl/spi_sync.sv | 25 ++
 rtl/spi_target.sv | 149 ++++++++++++++
 tb/tb_spi_target.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared SPI definitions: mode bit positions and target FSM states.
// Imported by the target engine, the master engine and config decode.
package spi_target_pkg;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines (cs_n) reset inactive.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target engine: oversampled sclk/cs_n/mosi, MSB-first shifters,
// all four CPOL/CPHA modes, tx underflow sends all ones.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_unf
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk), .rst_ni(rst), .d_i(sclk), .q_o(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk), .rst_ni(rst), .d_i(cs_n), .q_o(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk), .rst_ni(rst), .d_i(mosi), .q_o(mosi_s)
    );

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              sampled_q, sampled_d;
    logic              sclk_prev_q, cs_prev_q;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic lead_ev, trail_ev, sample_ev, drive_ev;
    logic load;
    logic [DATA_W-1:0] rx_next;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;

    // Edge roles come from the mode latched at cs_n assertion
    assign lead_ev   = mode_q[CPOL_BIT] ? sclk_fall : sclk_rise;
    assign trail_ev  = mode_q[CPOL_BIT] ? sclk_rise : sclk_fall;
    assign sample_ev = mode_q[CPHA_BIT] ? trail_ev : lead_ev;
    assign drive_ev  = mode_q[CPHA_BIT] ? lead_ev : trail_ev;
    assign rx_next   = {rx_shift_q[DATA_W-2:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        sampled_d  = sampled_q;
        load       = 1'b0;
        tx_ready   = 1'b0;
        tx_unf     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    mode_d    = mode;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sample_ev) begin
                    rx_shift_d = rx_next;
                    sampled_d  = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        load       = ~cs_rise;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (drive_ev && sampled_q) begin
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b1};
                end
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
        endcase
        // A reload holds the new MSB through the next drive edge
        if (load) begin
            sampled_d  = 1'b0;
            tx_shift_d = tx_valid ? tx_data : '1;
            tx_ready   = tx_valid;
            tx_unf     = ~tx_valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '1;
            sampled_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            sampled_q   <= sampled_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign miso     = tx_shift_q[DATA_W-1];
    assign miso_oe  = (state_q == ST_ACTIVE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: behavioural SPI master, tx source and rx sink,
// vector table, random frames and multi-cycle corner sequences.
module tb_spi_target;

    localparam time TCLK = 10;
    localparam time H    = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_unf;

    always #(TCLK/2) clk = ~clk;

    spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_unf(tx_unf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_list[$];
    logic [7:0] rx_got[$];
    int rd_idx = 0;
    int n_ready = 0;
    int n_unf = 0;
    bit pend = 1'b0;

    // tx source and rx sink: a byte is retired after the edge that took it
    always @(negedge clk) begin
        if (pend) begin
            rd_idx++;
            pend = 1'b0;
        end
        if (tx_ready) begin
            n_ready++;
            pend = 1'b1;
        end
        if (tx_unf) n_unf++;
        if (rx_valid) rx_got.push_back(rx_data);
        tx_valid = (rd_idx < tx_list.size());
        tx_data  = tx_valid ? tx_list[rd_idx] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural master: nbits under one cs_n, MSB first
    task automatic spi_xfer(input logic [1:0] m, input logic [15:0] dout,
                            input int nbits, input bit early, input bit hold,
                            output logic [15:0] din);
        din  = '0;
        mode = m;
        sclk = m[1];
        #(H);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                mosi = dout[nbits-1-i];
                #(H);
                sclk = ~m[1];
                din  = {din[14:0], miso};
                #(H);
                sclk = m[1];
            end else begin
                #(H);
                sclk = ~m[1];
                mosi = dout[nbits-1-i];
                #(H);
                sclk = m[1];
                din  = {din[14:0], miso};
                if (early && i == nbits - 1) cs_n = 1'b1;
            end
        end
        if (!hold) begin
            #(H);
            cs_n = 1'b1;
            #(2*H);
        end
    endtask

    // One frame, with expectations supplied by the caller's model/table
    task automatic run_frame(input string name, input logic [1:0] m,
                             input logic [7:0] txb, input bit txv,
                             input logic [7:0] mosib, input int nbits,
                             input bit early, input logic [7:0] exp_rx,
                             input logic [7:0] exp_miso);
        int r0, k0, u0, loads, exp_rdy;
        logic [15:0] got;
        r0 = rx_got.size();
        k0 = n_ready;
        u0 = n_unf;
        if (txv) tx_list.push_back(txb);
        repeat (2) @(negedge clk);
        spi_xfer(m, {8'h00, mosib}, nbits, early, 1'b0, got);
        repeat (4) @(negedge clk);
        chk({name, " miso"}, 32'(got[7:0]), 32'(exp_miso >> (8 - nbits)));
        if (nbits == 8) begin
            chk({name, " rx_cnt"}, rx_got.size() - r0, 1);
            if (rx_got.size() > r0) chk({name, " rx_data"}, 32'(rx_got[r0]), 32'(exp_rx));
        end else begin
            chk({name, " rx_cnt"}, rx_got.size() - r0, 0);
        end
        loads   = 1 + ((nbits == 8 && !early) ? 1 : 0);
        exp_rdy = txv ? 1 : 0;
        chk({name, " tx_ready"}, n_ready - k0, exp_rdy);
        chk({name, " tx_unf"}, n_unf - u0, loads - exp_rdy);
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] tx;
        bit         txv;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        int r0, k0, u0;
        logic [1:0] rm;
        logic [7:0] rtx, rmo;
        bit rv;

        vecs[0] = '{2'd0, 8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C};
        vecs[1] = '{2'd1, 8'h96, 1'b1, 8'h5A, 8'h5A, 8'h96};
        vecs[2] = '{2'd2, 8'h96, 1'b1, 8'h5A, 8'h5A, 8'h96};
        vecs[3] = '{2'd3, 8'h96, 1'b1, 8'h5A, 8'h5A, 8'h96};
        vecs[4] = '{2'd0, 8'h00, 1'b0, 8'h77, 8'h77, 8'hFF};
        vecs[5] = '{2'd2, 8'h01, 1'b1, 8'h80, 8'h80, 8'h01};

        repeat (4) @(negedge clk);
        chk("reset miso", 32'(miso), 1);
        chk("reset miso_oe", 32'(miso_oe), 0);
        chk("reset rx_data", 32'(rx_data), 0);
        chk("reset rx_valid", 32'(rx_valid), 0);
        chk("reset tx_ready", 32'(tx_ready), 0);
        chk("reset tx_unf", 32'(tx_unf), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].m, vecs[i].tx,
                      vecs[i].txv, vecs[i].mosi, 8, 1'b0,
                      vecs[i].exp_rx, vecs[i].exp_miso);
        end

        // Two bytes under one cs_n in mode 1
        r0 = rx_got.size();
        k0 = n_ready;
        u0 = n_unf;
        tx_list.push_back(8'hAB);
        tx_list.push_back(8'hCD);
        repeat (2) @(negedge clk);
        spi_xfer(2'd1, 16'h1234, 16, 1'b0, 1'b0, got);
        repeat (4) @(negedge clk);
        chk("b2b miso", 32'(got), 32'hABCD);
        chk("b2b rx_cnt", rx_got.size() - r0, 2);
        if (rx_got.size() >= r0 + 2) begin
            chk("b2b rx0", 32'(rx_got[r0]), 32'h12);
            chk("b2b rx1", 32'(rx_got[r0+1]), 32'h34);
        end
        chk("b2b tx_ready", n_ready - k0, 2);
        chk("b2b tx_unf", n_unf - u0, 1);

        // Partial frame dropped, next full frame received
        run_frame("partial", 2'd2, 8'hE7, 1'b1, 8'h1F, 5, 1'b0, 8'h00, 8'hE7);
        run_frame("after_partial", 2'd2, 8'h42, 1'b1, 8'hC3, 8, 1'b0, 8'hC3, 8'h42);

        // cs_n rises together with the final sample edge
        run_frame("early_cs", 2'd3, 8'h81, 1'b1, 8'h7E, 8, 1'b1, 8'h7E, 8'h81);

        // Reset in the middle of a frame
        tx_list.push_back(8'h5A);
        repeat (2) @(negedge clk);
        spi_xfer(2'd0, 16'h00F0, 4, 1'b0, 1'b1, got);
        @(negedge clk);
        chk("mid miso_oe", 32'(miso_oe), 1);
        chk("mid miso bits", 32'(got[3:0]), 32'h5);
        rst = 1'b0;
        #1;
        chk("rst miso", 32'(miso), 1);
        chk("rst miso_oe", 32'(miso_oe), 0);
        chk("rst rx_data", 32'(rx_data), 0);
        chk("rst rx_valid", 32'(rx_valid), 0);
        chk("rst tx_ready", 32'(tx_ready), 0);
        chk("rst tx_unf", 32'(tx_unf), 0);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_frame("after_rst", 2'd0, 8'h69, 1'b1, 8'hD2, 8, 1'b0, 8'hD2, 8'h69);

        // Random frames against the byte-level model
        for (int i = 0; i < 16; i++) begin
            rm  = 2'($urandom_range(0, 3));
            rtx = 8'($urandom);
            rmo = 8'($urandom);
            rv  = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", i), rm, rtx, rv, rmo, 8, 1'b0,
                      rmo, rv ? rtx : 8'hFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
